// File: rtl/mult_float_stage.sv
// Pipelined binary32 multiplier feeding the adderFloat accumulator.
// Four register ranks (classify, multiply, normalise, round/pack): result appears three edges after capture.
module mult_float_stage #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             inValid,
  input  logic             inFirst,
  output logic [WIDTH-1:0] product,
  output logic             Add,
  output logic             first
);

  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int E_W    = EXP_W + 2;
  localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;

  typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_INF, SP_NAN} special_t;

  // Operand unpack and classification
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  special_t         in_sp;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    in_sp = SP_NONE;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      in_sp = SP_NAN;
    else if (a_inf || b_inf)
      in_sp = SP_INF;
    else if (a_zero || b_zero)
      in_sp = SP_ZERO;
  end

  // Stage registers
  logic                    s1_valid, s1_first, s1_sign;
  special_t                s1_sp;
  logic [EXP_W-1:0]        s1_ea, s1_eb;
  logic [SIG_W-1:0]        s1_ma, s1_mb;

  logic                    s2_valid, s2_first, s2_sign;
  special_t                s2_sp;
  logic signed [E_W-1:0]   s2_e;
  logic [PROD_W-1:0]       s2_p;

  logic                    s3_valid, s3_first, s3_sign;
  special_t                s3_sp;
  logic signed [E_W-1:0]   s3_e;
  logic [MAN_W-1:0]        s3_man;
  logic                    s3_guard, s3_sticky;

  // Normalise the 48-bit significand product
  logic [MAN_W-1:0]      n_man;
  logic                  n_guard, n_sticky;
  logic signed [E_W-1:0] n_e;

  always_comb begin
    n_man    = s2_p[PROD_W-3 -: MAN_W];
    n_guard  = s2_p[PROD_W-3-MAN_W];
    n_sticky = |s2_p[PROD_W-4-MAN_W:0];
    n_e      = s2_e;
    if (s2_p[PROD_W-1]) begin
      n_man    = s2_p[PROD_W-2 -: MAN_W];
      n_guard  = s2_p[PROD_W-2-MAN_W];
      n_sticky = |s2_p[PROD_W-3-MAN_W:0];
      n_e      = s2_e + E_W'(1);
    end
  end

  // Round to nearest even, then pack with special-case priority
  logic                  round_up, carry;
  logic [MAN_W-1:0]      r_man;
  logic signed [E_W-1:0] r_e;
  logic [WIDTH-1:0]      packed_res;

  always_comb begin
    round_up     = s3_guard && (s3_sticky || s3_man[0]);
    {carry, r_man} = {1'b0, s3_man} + (MAN_W + 1)'(round_up);
    r_e          = s3_e + E_W'(carry);
    packed_res   = {s3_sign, r_e[EXP_W-1:0], r_man};
    unique case (s3_sp)
      SP_NAN:  packed_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      SP_INF:  packed_res = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      SP_ZERO: packed_res = {s3_sign, {(WIDTH-1){1'b0}}};
      default: begin
        if (r_e >= E_MAX)
          packed_res = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (r_e <= E_ZERO)
          packed_res = {s3_sign, {(WIDTH-1){1'b0}}};
      end
    endcase
  end

  // Control path: valids, first flags and outputs are reset so in-flight work is dropped.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_first <= 1'b0;
      s2_first <= 1'b0;
      s3_first <= 1'b0;
      Add      <= 1'b0;
      first    <= 1'b0;
      product  <= '0;
    end else begin
      s1_valid <= inValid;
      s1_first <= inValid && inFirst;
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s3_valid <= s2_valid;
      s3_first <= s2_first;
      Add      <= s3_valid;
      first    <= s3_valid && s3_first;
      if (s3_valid)
        product <= packed_res;
    end
  end

  // NOTE: datapath registers carry no reset; their contents are only observed behind a valid bit.
  always_ff @(posedge Clk) begin
    s1_sign   <= sa ^ sb;
    s1_sp     <= in_sp;
    s1_ea     <= ea;
    s1_eb     <= eb;
    s1_ma     <= {1'b1, fa};
    s1_mb     <= {1'b1, fb};

    s2_sign   <= s1_sign;
    s2_sp     <= s1_sp;
    s2_e      <= E_W'(s1_ea) + E_W'(s1_eb) - E_W'(BIAS);
    s2_p      <= PROD_W'(s1_ma) * PROD_W'(s1_mb);

    s3_sign   <= s2_sign;
    s3_sp     <= s2_sp;
    s3_e      <= n_e;
    s3_man    <= n_man;
    s3_guard  <= n_guard;
    s3_sticky <= n_sticky;
  end

endmodule

// File: tb/tb_mult_float_stage.sv
// Directed bench for mult_float_stage: expected products queued at drive time, checked when Add rises.
module tb_mult_float_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] a, b;
  logic        inValid, inFirst;
  logic [31:0] product;
  logic        Add, first;

  mult_float_stage dut (
    .Clk(Clk), .Rst(Rst), .a(a), .b(b), .inValid(inValid), .inFirst(inFirst),
    .product(product), .Add(Add), .first(first)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] prod;
    logic        fst;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_prod = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge Clk) begin
    exp_t e;
    if (mon_en) begin
      if (Add === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_add", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("product", product, e.prod);
          check("first", {31'b0, first}, {31'b0, e.fst});
          check("latency", cyc, e.due);
          last_prod = e.prod;
        end
      end else begin
        check("add_idle", {31'b0, Add}, 32'd0);
        check("first_idle", {31'b0, first}, 32'd0);
        check("hold", product, last_prod);
        if (sb.size() != 0 && cyc >= sb[0].due) begin
          check("missing_add", 32'd0, 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic f,
                      input logic [31:0] want);
    a = x;
    b = y;
    inFirst = f;
    inValid = 1'b1;
    sb.push_back('{want, f, cyc + 4});
    @(posedge Clk);
    #1;
    inValid = 1'b0;
    inFirst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b1;
    inValid = 1'b0;
    inFirst = 1'b0;
    a = '0;
    b = '0;
    idle(2);
    Rst = 1'b0;
    mon_en = 1'b1;

    // Single product, then idle to confirm no extra Add
    send(32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000);
    idle(5);

    // Back-to-back stream, rounding cases
    send(32'hBFC00000, 32'h40000000, 1'b0, 32'hC0400000);
    send(32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002);
    send(32'h3F800001, 32'h3F800000, 1'b0, 32'h3F800001);
    send(32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002);
    idle(5);

    // Overflow, underflow and special operands
    send(32'h7F7FFFFF, 32'h40000000, 1'b0, 32'h7F800000);
    send(32'h0D800000, 32'h0D800000, 1'b0, 32'h00000000);
    send(32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000);
    send(32'h00000000, 32'hFF800000, 1'b0, 32'h7FC00000);
    send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000);
    send(32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000);
    send(32'h80000000, 32'h40A00000, 1'b0, 32'h80000000);
    send(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1, 32'h407FFFFE);
    idle(5);

    // Bubbles between products; inFirst without inValid is ignored
    send(32'h40000000, 32'h40000000, 1'b1, 32'h40800000);
    inFirst = 1'b1;
    idle(1);
    inFirst = 1'b0;
    send(32'hC0000000, 32'h3F000000, 1'b0, 32'hBF800000);
    idle(6);

    // Reset one edge after a valid pair is accepted
    send(32'h40400000, 32'h40000000, 1'b1, 32'h40C00000);
    Rst = 1'b1;
    idle(1);
    Rst = 1'b0;
    sb.delete();
    last_prod = '0;
    idle(5);

    // Dot-product feed {1,2}.{3,4}
    send(32'h3F800000, 32'h40400000, 1'b1, 32'h40400000);
    send(32'h40000000, 32'h40800000, 1'b0, 32'h41000000);
    idle(6);

    if (sb.size() != 0)
      check("drain", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
